// File: rtl/stroke_sched.sv
// -----------------------------------------------------------------------------
// stroke_sched
// Sequencer for one painterly stroke layer. The canvas is scanned on a grid
// whose pitch is the brush radius R. One stroke is launched per grid cell.
// The block walks each stroke through the external per-step engine, one
// control point at a time, and streams the control points to the rasteriser.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 start a layer (sampled only when idle)
//   i_abort                 abandon the layer from any state (highest priority)
//   i_radius[3:0]           brush radius / grid pitch (0 is used as 1)
//   o_step_req              step request to the engine
//   o_step_x/y[9:0]         current point sent to the engine
//   o_step_first            current point starts a stroke
//   i_step_ack              engine response valid
//   i_step_nx/ny[10:0]      next point, two's complement
//   i_step_stop             engine termination request
//   o_pt_valid/i_pt_ready   control point handshake to the rasteriser
//   o_pt_x/y[9:0]           control point coordinates
//   o_pt_idx[5:0]           point index within the stroke
//   o_pt_last               final point of the stroke
//   o_busy                  high whenever not idle
//   o_done                  one-cycle pulse at layer completion
//   o_stroke_cnt[15:0]      strokes launched this layer (saturating)
// -----------------------------------------------------------------------------
module stroke_sched #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [3:0]  i_radius,
    output logic        o_step_req,
    output logic [9:0]  o_step_x,
    output logic [9:0]  o_step_y,
    output logic        o_step_first,
    input  logic        i_step_ack,
    input  logic [10:0] i_step_nx,
    input  logic [10:0] i_step_ny,
    input  logic        i_step_stop,
    output logic        o_pt_valid,
    input  logic        i_pt_ready,
    output logic [9:0]  o_pt_x,
    output logic [9:0]  o_pt_y,
    output logic [5:0]  o_pt_idx,
    output logic        o_pt_last,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_stroke_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_EMIT = 3'd2,
        S_ADV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [10:0] W_L      = 11'(IMG_W);
    localparam logic [10:0] H_L      = 11'(IMG_H);
    localparam logic [9:0]  X_MAX    = 10'(IMG_W - 1);
    localparam logic [9:0]  Y_MAX    = 10'(IMG_H - 1);
    localparam logic [5:0]  LAST_IDX = 6'(MAX_LEN - 1);
    localparam logic [6:0]  MIN_L    = 7'(MIN_LEN);

    // Cell centre along one axis: origin plus half the pitch, clamped to the canvas.
    function automatic logic [9:0] centre(input logic [9:0] org,
                                          input logic [2:0] half,
                                          input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, org} + {8'd0, half};
        centre = (sum > {1'b0, lim}) ? lim : sum[9:0];
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  rad_r, rad_s;
    logic [9:0]  ox_r, ox_s, oy_r, oy_s;
    logic [9:0]  cur_x_r, cur_x_s, cur_y_r, cur_y_s;
    logic [9:0]  nx_r, nx_s, ny_r, ny_s;
    logic [5:0]  idx_r, idx_s;
    logic        first_r, first_s;
    logic        term_r, term_s;
    logic [15:0] cnt_r, cnt_s;
    logic        step_req_r, pt_valid_r, busy_r, done_r;

    logic [3:0]  rad_in_s;
    logic [10:0] next_ox_s, next_oy_s;
    logic        oob_s, min_ok_s;
    logic [15:0] cnt_inc_s;

    assign rad_in_s  = (i_radius == 4'd0) ? 4'd1 : i_radius;
    assign next_ox_s = {1'b0, ox_r} + {7'd0, rad_r};
    assign next_oy_s = {1'b0, oy_r} + {7'd0, rad_r};
    // A negative response has bit 10 set, so it also fails the upper compare.
    assign oob_s     = i_step_nx[10] || (i_step_nx >= W_L) ||
                       i_step_ny[10] || (i_step_ny >= H_L);
    assign min_ok_s  = (({1'b0, idx_r} + 7'd1) >= MIN_L);
    assign cnt_inc_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);

    // Next-state and datapath register updates.
    always_comb begin
        state_s = state_r;
        rad_s   = rad_r;
        ox_s    = ox_r;
        oy_s    = oy_r;
        cur_x_s = cur_x_r;
        cur_y_s = cur_y_r;
        nx_s    = nx_r;
        ny_s    = ny_r;
        idx_s   = idx_r;
        first_s = first_r;
        term_s  = term_r;
        cnt_s   = cnt_r;
        if (i_abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        rad_s   = rad_in_s;
                        ox_s    = 10'd0;
                        oy_s    = 10'd0;
                        cur_x_s = centre(10'd0, rad_in_s[3:1], X_MAX);
                        cur_y_s = centre(10'd0, rad_in_s[3:1], Y_MAX);
                        idx_s   = 6'd0;
                        first_s = 1'b1;
                        term_s  = 1'b0;
                        cnt_s   = 16'd1;
                        state_s = S_STEP;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_STEP: begin
                    if (i_step_ack) begin
                        nx_s    = i_step_nx[9:0];
                        ny_s    = i_step_ny[9:0];
                        term_s  = oob_s || (i_step_stop && min_ok_s);
                        state_s = S_EMIT;
                    end else begin
                        state_s = S_STEP;
                    end
                end
                S_EMIT: begin
                    if (i_pt_ready) begin
                        if (term_r) begin
                            state_s = S_ADV;
                        end else begin
                            cur_x_s = nx_r;
                            cur_y_s = ny_r;
                            idx_s   = idx_r + 6'd1;
                            first_s = 1'b0;
                            // The final permitted point needs no engine step.
                            if ((idx_r + 6'd1) == LAST_IDX) begin
                                term_s  = 1'b1;
                                state_s = S_EMIT;
                            end else begin
                                term_s  = 1'b0;
                                state_s = S_STEP;
                            end
                        end
                    end else begin
                        state_s = S_EMIT;
                    end
                end
                S_ADV: begin
                    if (next_ox_s < W_L) begin
                        ox_s    = next_ox_s[9:0];
                        cur_x_s = centre(next_ox_s[9:0], rad_r[3:1], X_MAX);
                        cur_y_s = centre(oy_r, rad_r[3:1], Y_MAX);
                        idx_s   = 6'd0;
                        first_s = 1'b1;
                        term_s  = 1'b0;
                        cnt_s   = cnt_inc_s;
                        state_s = S_STEP;
                    end else if (next_oy_s < H_L) begin
                        ox_s    = 10'd0;
                        oy_s    = next_oy_s[9:0];
                        cur_x_s = centre(10'd0, rad_r[3:1], X_MAX);
                        cur_y_s = centre(next_oy_s[9:0], rad_r[3:1], Y_MAX);
                        idx_s   = 6'd0;
                        first_s = 1'b1;
                        term_s  = 1'b0;
                        cnt_s   = cnt_inc_s;
                        state_s = S_STEP;
                    end else begin
                        state_s = S_DONE;
                    end
                end
                S_DONE: begin
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered output flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= S_IDLE;
            rad_r      <= 4'd0;
            ox_r       <= 10'd0;
            oy_r       <= 10'd0;
            cur_x_r    <= 10'd0;
            cur_y_r    <= 10'd0;
            nx_r       <= 10'd0;
            ny_r       <= 10'd0;
            idx_r      <= 6'd0;
            first_r    <= 1'b0;
            term_r     <= 1'b0;
            cnt_r      <= 16'd0;
            step_req_r <= 1'b0;
            pt_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            rad_r      <= rad_s;
            ox_r       <= ox_s;
            oy_r       <= oy_s;
            cur_x_r    <= cur_x_s;
            cur_y_r    <= cur_y_s;
            nx_r       <= nx_s;
            ny_r       <= ny_s;
            idx_r      <= idx_s;
            first_r    <= first_s;
            term_r     <= term_s;
            cnt_r      <= cnt_s;
            step_req_r <= (state_s == S_STEP);
            pt_valid_r <= (state_s == S_EMIT);
            busy_r     <= (state_s != S_IDLE);
            done_r     <= (state_s == S_DONE);
        end
    end

    assign o_step_req   = step_req_r;
    assign o_step_x     = cur_x_r;
    assign o_step_y     = cur_y_r;
    assign o_step_first = first_r;
    assign o_pt_valid   = pt_valid_r;
    assign o_pt_x       = cur_x_r;
    assign o_pt_y       = cur_y_r;
    assign o_pt_idx     = idx_r;
    assign o_pt_last    = term_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_stroke_cnt = cnt_r;

endmodule

// File: tb/tb_stroke_sched.sv
// -----------------------------------------------------------------------------
// tb_stroke_sched
// Self-checking bench for stroke_sched on an 8x8 canvas. A reference model
// enumerates the grid cells and walks each stroke with the same engine
// behaviour the bench drives, producing the expected step requests and
// control points, which are compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_stroke_sched;

    localparam int IMG   = 8;
    localparam int MIN_L = 4;
    localparam int MAX_L = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [3:0]  radius;
    logic        step_req, step_first, step_ack, step_stop;
    logic [9:0]  step_x, step_y;
    logic [10:0] step_nx, step_ny;
    logic        pt_valid, pt_ready, pt_last, busy, done;
    logic [9:0]  pt_x, pt_y;
    logic [5:0]  pt_idx;
    logic [15:0] stroke_cnt;

    stroke_sched #(.IMG_W(IMG), .IMG_H(IMG), .MIN_LEN(MIN_L), .MAX_LEN(MAX_L)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_radius(radius),
        .o_step_req(step_req), .o_step_x(step_x), .o_step_y(step_y),
        .o_step_first(step_first), .i_step_ack(step_ack),
        .i_step_nx(step_nx), .i_step_ny(step_ny), .i_step_stop(step_stop),
        .o_pt_valid(pt_valid), .i_pt_ready(pt_ready),
        .o_pt_x(pt_x), .o_pt_y(pt_y), .o_pt_idx(pt_idx), .o_pt_last(pt_last),
        .o_busy(busy), .o_done(done), .o_stroke_cnt(stroke_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] idx;
        logic       last;
    } pt_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       first;
    } st_t;

    pt_t exp_pts[$];
    st_t exp_steps[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int unsigned mix(input int unsigned a);
        a = a ^ (a >> 16);
        a = a * 32'h7feb352d;
        a = a ^ (a >> 15);
        a = a * 32'h846ca68b;
        a = a ^ (a >> 16);
        return a;
    endfunction

    // Engine behaviour for stroke s, step k from point (x,y).
    task automatic engine(input int mode, input int unsigned seed, input int s, input int k,
                          input int x, input int y,
                          output int nx, output int ny, output bit stop);
        int unsigned h;
        case (mode)
            0: begin nx = x; ny = y; stop = 1'b1; end
            1: begin nx = (x + 1) % 5; ny = y; stop = 1'b0; end
            2: begin nx = (k == 1) ? -1 : x; ny = y; stop = 1'b0; end
            default: begin
                h    = mix(seed ^ (32'(s) * 32'd64 + 32'(k)));
                nx   = int'(h % 10) - 1;
                ny   = int'((h >> 8) % 10) - 1;
                stop = h[20];
            end
        endcase
    endtask

    // Expected steps/points for a whole layer.
    task automatic build_model(input int r, input int mode, input int unsigned seed,
                               output int n_str, output int n_steps);
        int rr, s, x, y, i, nx, ny;
        bit st, term;
        rr = (r == 0) ? 1 : r;
        s = 0;
        n_steps = 0;
        exp_pts.delete();
        exp_steps.delete();
        for (int oy = 0; oy < IMG; oy += rr) begin
            for (int ox = 0; ox < IMG; ox += rr) begin
                x = (ox + rr / 2 > IMG - 1) ? IMG - 1 : ox + rr / 2;
                y = (oy + rr / 2 > IMG - 1) ? IMG - 1 : oy + rr / 2;
                i = 0;
                term = 1'b0;
                while (!term) begin
                    if (i == MAX_L - 1) begin
                        exp_pts.push_back('{10'(x), 10'(y), 6'(i), 1'b1});
                        term = 1'b1;
                    end else begin
                        exp_steps.push_back('{10'(x), 10'(y), (i == 0)});
                        n_steps++;
                        engine(mode, seed, s, i, x, y, nx, ny, st);
                        term = (nx < 0) || (nx >= IMG) || (ny < 0) || (ny >= IMG) ||
                               (st && (i + 1 >= MIN_L));
                        exp_pts.push_back('{10'(x), 10'(y), 6'(i), term});
                        x = nx;
                        y = ny;
                        i++;
                    end
                end
                s++;
            end
        end
        n_str = s;
    endtask

    task automatic run_layer(input int r, input int mode, input int unsigned seed, input bit stall);
        int n_str, n_st, es, ek, nx, ny, steps_seen, dn;
        bit st, fin, w_step, w_pt, a_prev, hs_prev;
        st_t h_step, e_step;
        pt_t h_pt, e_pt;
        build_model(r, mode, seed, n_str, n_st);
        es = -1; ek = 0; steps_seen = 0; dn = 0;
        fin = 1'b0; w_step = 1'b0; w_pt = 1'b0; a_prev = 1'b0; hs_prev = 1'b0;
        radius = 4'(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cnt", 32'(stroke_cnt), 32'd1);
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            if (w_step) chk("step_hold", 32'({step_req, step_x, step_y, step_first}), 32'({1'b1, h_step}));
            if (w_pt)   chk("pt_hold", 32'({pt_valid, pt_x, pt_y, pt_idx, pt_last}), 32'({1'b1, h_pt}));
            if (a_prev) chk("ack_to_pt", 32'(pt_valid), 32'd1);
            if (hs_prev) chk("hs_to_next", 32'(step_req | pt_valid), 32'd1);
            w_step = 1'b0; w_pt = 1'b0; a_prev = 1'b0; hs_prev = 1'b0;
            step_ack = 1'b0;
            if (step_req) begin
                if (!stall || $urandom_range(2) == 0) begin
                    if (step_first) begin es++; ek = 0; end
                    else ek++;
                    engine(mode, seed, es, ek, int'(step_x), int'(step_y), nx, ny, st);
                    step_ack  = 1'b1;
                    step_nx   = 11'(nx);
                    step_ny   = 11'(ny);
                    step_stop = st;
                    steps_seen++;
                    a_prev = 1'b1;
                    if (exp_steps.size() == 0) begin
                        chk("step_extra", 32'd1, 32'd0);
                    end else begin
                        e_step = exp_steps.pop_front();
                        chk("step", 32'({step_x, step_y, step_first}), 32'(e_step));
                    end
                end else begin
                    w_step = 1'b1;
                    h_step = '{step_x, step_y, step_first};
                end
            end
            pt_ready = !stall || ($urandom_range(1) == 0);
            if (pt_valid) begin
                if (pt_ready) begin
                    hs_prev = !pt_last;
                    if (exp_pts.size() == 0) begin
                        chk("pt_extra", 32'd1, 32'd0);
                    end else begin
                        e_pt = exp_pts.pop_front();
                        chk("point", 32'({pt_x, pt_y, pt_idx, pt_last}), 32'(e_pt));
                    end
                end else begin
                    w_pt = 1'b1;
                    h_pt = '{pt_x, pt_y, pt_idx, pt_last};
                end
            end
            if (done) begin
                dn++;
                fin = 1'b1;
                chk("done_cnt", 32'(stroke_cnt), 32'(n_str));
            end
            if (!fin) @(negedge clk);
        end
        chk("timeout", 32'(fin), 32'd1);
        step_ack = 1'b0;
        pt_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("cnt_hold", 32'(stroke_cnt), 32'(n_str));
        repeat (3) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("done_pulses", 32'(dn), 32'd1);
        chk("step_total", 32'(steps_seen), 32'(n_st));
        chk("pts_left", 32'(exp_pts.size()), 32'd0);
        chk("steps_left", 32'(exp_steps.size()), 32'd0);
    endtask

    task automatic abort_test();
        int dn;
        bit hit;
        hit = 1'b0;
        radius = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Every stroke ends at once (out of bounds); stall on stroke 3's point.
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            step_ack = step_req;
            step_nx = 11'h7FF;
            step_ny = {1'b0, step_y};
            step_stop = 1'b0;
            pt_ready = (stroke_cnt < 16'd3);
            if (pt_valid && stroke_cnt == 16'd3) hit = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reach", 32'(hit), 32'd1);
        step_ack = 1'b0;
        pt_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 32'(pt_valid), 32'd0);
        chk("abort_req", 32'(step_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        dn = 0;
        repeat (5) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; radius = 4'd0;
        step_ack = 1'b0; step_nx = 11'd0; step_ny = 11'd0; step_stop = 1'b0;
        pt_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'({step_req, pt_valid, busy, done, step_first, pt_last}), 32'd0);
        chk("rst_cnt", 32'(stroke_cnt), 32'd0);
        chk("rst_pt", 32'({pt_x, pt_y, pt_idx}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_flags", 32'({step_req, pt_valid, busy, done}), 32'd0);

        run_layer(4, 0, 32'd1, 1'b0);   // 4 strokes x 4 points
        run_layer(0, 0, 32'd2, 1'b0);   // radius 0 used as 1
        run_layer(4, 1, 32'd3, 1'b0);   // length limit
        run_layer(4, 2, 32'd4, 1'b0);   // out of bounds before MIN_LEN
        run_layer(4, 1, 32'd5, 1'b1);   // stalls on the length-limit walk
        run_layer(15, 0, 32'd6, 1'b0);  // single clamped cell
        for (int t = 0; t < 6; t++) begin
            run_layer(int'($urandom_range(15)), 3, $urandom, 1'b1);
        end
        abort_test();
        run_layer(4, 0, 32'd7, 1'b0);   // restart after abort

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
